// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed load/store front end for a word-wide data RAM.
// Optional macro DMC_SUBWORD_EN enables byte/halfword loads (extract + extend) and stores (read-modify-write).
module data_mem_ctrl #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA    = 32
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic                              REQ,
  input  logic                              WE,
  input  logic [1:0]                        SIZE,
  input  logic                              UNSIGNED_LD,
  input  logic [31:0]                       ADDR,
  input  logic [TAM_PALABRA-1:0]            WDATA,
  output logic [TAM_PALABRA-1:0]            RDATA,
  output logic                              READY,
  output logic                              ERR,
  output logic                              BUSY,
  output logic                              MEM_WRITE,
  output logic                              MEM_READ,
  output logic [$clog2(TAM_POSICIONES)-1:0] MEM_ADDRESS,
  output logic [TAM_PALABRA-1:0]            MEM_WDATA,
  input  logic [TAM_PALABRA-1:0]            MEM_RDATA
);

  localparam int AW = $clog2(TAM_POSICIONES);

  // Handshake: REQ and its fields are sampled only in IDLE (BUSY=0). Every accepted
  // request yields exactly one READY pulse, with ERR=1 if it was rejected; REQ seen
  // while BUSY=1 is dropped, never queued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_q;
  logic [TAM_PALABRA-1:0] rdata_q;
  logic                   ready_q;
  logic                   err_q;
  logic                   mem_write_q;
  logic                   mem_read_q;
  logic [AW-1:0]          mem_address_q;
  logic [TAM_PALABRA-1:0] mem_wdata_q;
  logic                   req_ok;

  // Only the word-index bits of ADDR matter; the rest wrap modulo RAM size.
  logic unused_addr;
  assign unused_addr = ^ADDR[31:AW+2];

  always_comb begin
    req_ok = 1'b0;
    case (SIZE)
`ifdef DMC_SUBWORD_EN
      2'b00:   req_ok = 1'b1;
      2'b01:   req_ok = ~ADDR[0];
`endif
      2'b10:   req_ok = (ADDR[1:0] == 2'b00);
      default: req_ok = 1'b0;
    endcase
  end

`ifdef DMC_SUBWORD_EN
  logic                   we_q;
  logic [1:0]             size_q;
  logic                   uns_q;
  logic [1:0]             off_q;
  logic [15:0]            wdata_q;
  logic [7:0]             lane_b;
  logic [15:0]            lane_h;
  logic [TAM_PALABRA-1:0] load_ext;
  logic [TAM_PALABRA-1:0] merge_word;

  // Extraction and merge both work on the word arriving from the RAM in the RD cycle.
  always_comb begin
    lane_b = MEM_RDATA[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_ext = MEM_RDATA;
    endcase
    merge_word = MEM_RDATA;
    if (size_q == 2'b00) begin
      merge_word[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_word[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end
`else
  logic unused_uns;
  assign unused_uns = UNSIGNED_LD;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      rdata_q       <= '0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
`ifdef DMC_SUBWORD_EN
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      off_q         <= 2'b00;
      wdata_q       <= '0;
`endif
    end else begin
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (REQ) begin
`ifdef DMC_SUBWORD_EN
            we_q    <= WE;
            size_q  <= SIZE;
            uns_q   <= UNSIGNED_LD;
            off_q   <= ADDR[1:0];
            wdata_q <= WDATA[15:0];
`endif
            if (!req_ok) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end else if (WE && (SIZE == 2'b10)) begin
              state_q       <= WR;
              mem_address_q <= ADDR[AW+1:2];
              mem_write_q   <= 1'b1;
              mem_wdata_q   <= WDATA;
            end else begin
              state_q       <= RD;
              mem_address_q <= ADDR[AW+1:2];
              mem_read_q    <= 1'b1;
            end
          end
        end
        RD: begin
`ifdef DMC_SUBWORD_EN
          if (we_q) begin
            state_q     <= WR;
            mem_write_q <= 1'b1;
            mem_wdata_q <= merge_word;
          end else begin
            state_q <= DONE;
            ready_q <= 1'b1;
            rdata_q <= load_ext;
          end
`else
          state_q <= DONE;
          ready_q <= 1'b1;
          rdata_q <= MEM_RDATA;
`endif
        end
        WR: begin
          state_q <= DONE;
          ready_q <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RDATA       = rdata_q;
  assign READY       = ready_q;
  assign ERR         = err_q;
  assign BUSY        = (state_q != IDLE);
  assign MEM_WRITE   = mem_write_q;
  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = mem_address_q;
  assign MEM_WDATA   = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural word RAM; sub-word scenarios follow DMC_SUBWORD_EN.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;
  logic        mem_write;
  logic        mem_read;
  logic [9:0]  mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];
  int n_vec = 0;
  int n_err = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int ready_pulses = 0;

  data_mem_ctrl #(.TAM_POSICIONES(1024), .TAM_PALABRA(32)) dut (
    .CLK(clk), .RESET_N(rst_n), .REQ(req), .WE(we), .SIZE(size), .UNSIGNED_LD(uns),
    .ADDR(addr), .WDATA(wdata), .RDATA(rdata), .READY(ready), .ERR(err), .BUSY(busy),
    .MEM_WRITE(mem_write), .MEM_READ(mem_read), .MEM_ADDRESS(mem_address),
    .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = mem[mem_address];
  always @(posedge clk) if (mem_write) mem[mem_address] = mem_wdata;

  always @(negedge clk) begin
    if (mem_read) rd_pulses++;
    if (mem_write) wr_pulses++;
    if (ready) ready_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle, then scrambles the fields so only latched values can be used.
  task automatic issue(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
    step();
    req = 1'b0; we = ~w; size = 2'b11; uns = ~u; addr = 32'hFFFF_FFFF; wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    repeat (2) step();
    n_vec++;
    if ({rdata, ready, err, busy, mem_write, mem_read, mem_address, mem_wdata} !== 79'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rdata, ready, err, busy, mem_write, mem_read, mem_address, mem_wdata});
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_word_store();
    mem[4] = 32'h0;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    n_vec++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 10'd4 || mem_wdata !== 32'hDEAD_BEEF || ready !== 1'b0) begin
      n_err++;
      $display("FAIL wstore_wr_cycle: got wr=%b rd=%b a=%0d wd=%h rdy=%b expected wr=1 rd=0 a=4 wd=deadbeef rdy=0",
               mem_write, mem_read, mem_address, mem_wdata, ready);
    end
    step();
    n_vec++;
    if (ready !== 1'b1 || err !== 1'b0 || mem_write !== 1'b0 || mem[4] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL wstore_done: got rdy=%b err=%b wr=%b ram=%h expected rdy=1 err=0 wr=0 ram=deadbeef",
               ready, err, mem_write, mem[4]);
    end
    step();
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    n_vec++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 10'd4 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL wload_rd_cycle: got rd=%b wr=%b a=%0d rdy=%b expected rd=1 wr=0 a=4 rdy=0",
               mem_read, mem_write, mem_address, ready);
    end
    step();
    n_vec++;
    if (ready !== 1'b1 || err !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL wload_done: got rdy=%b err=%b rdata=%h expected rdy=1 err=0 rdata=deadbeef", ready, err, rdata);
    end
    step();
    n_vec++;
    if (busy !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL wload_hold: got busy=%b rdata=%h expected busy=0 rdata=deadbeef", busy, rdata);
    end
  endtask

  task automatic test_subword_store();
    mem[4] = 32'h1122_3344;
    mem[5] = 32'h5566_7788;
`ifdef DMC_SUBWORD_EN
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FFAB);
    n_vec++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 10'd4) begin
      n_err++;
      $display("FAIL rmw_rd_cycle: got rd=%b wr=%b a=%0d expected rd=1 wr=0 a=4", mem_read, mem_write, mem_address);
    end
    step();
    n_vec++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 10'd4 || mem_wdata !== 32'h11AB_3344 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_wr_cycle: got wr=%b rd=%b a=%0d wd=%h rdy=%b expected wr=1 rd=0 a=4 wd=11ab3344 rdy=0",
               mem_write, mem_read, mem_address, mem_wdata, ready);
    end
    step();
    n_vec++;
    if (ready !== 1'b1 || err !== 1'b0 || mem[4] !== 32'h11AB_3344) begin
      n_err++;
      $display("FAIL rmw_byte_done: got rdy=%b err=%b ram=%h expected rdy=1 err=0 ram=11ab3344", ready, err, mem[4]);
    end
    step();
    issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_CAFE);
    step();
    step();
    n_vec++;
    if (ready !== 1'b1 || err !== 1'b0 || mem[5] !== 32'hCAFE_7788) begin
      n_err++;
      $display("FAIL rmw_half_done: got rdy=%b err=%b ram=%h expected rdy=1 err=0 ram=cafe7788", ready, err, mem[5]);
    end
    step();
`else
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FFAB);
    n_vec++;
    if (ready !== 1'b1 || err !== 1'b1 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL subword_store_rejected: got rdy=%b err=%b wr=%b rd=%b expected rdy=1 err=1 wr=0 rd=0",
               ready, err, mem_write, mem_read);
    end
    step();
    n_vec++;
    if (mem[4] !== 32'h1122_3344) begin
      n_err++;
      $display("FAIL subword_store_ram: got %h expected 11223344", mem[4]);
    end
`endif
  endtask

  task automatic test_extension();
    logic [31:0] a_t [5] = '{32'h18, 32'h18, 32'h1A, 32'h19, 32'h18};
    logic [1:0]  s_t [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
    logic        u_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] e_t [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_8000, 32'hFFFF_FFF0, 32'h0000_F0FF};
    mem[6] = 32'h8000_F0FF;
`ifdef DMC_SUBWORD_EN
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, s_t[i], u_t[i], a_t[i], 32'h0);
      step();
      n_vec++;
      if (ready !== 1'b1 || err !== 1'b0 || rdata !== e_t[i]) begin
        n_err++;
        $display("FAIL ext_load_%0d: got rdy=%b err=%b rdata=%h expected rdy=1 err=0 rdata=%h",
                 i, ready, err, rdata, e_t[i]);
      end
      step();
    end
`else
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, s_t[i], u_t[i], a_t[i], 32'h0);
      n_vec++;
      if (ready !== 1'b1 || err !== 1'b1 || rdata !== 32'hDEAD_BEEF || e_t[i] === 32'h0) begin
        n_err++;
        $display("FAIL ext_rejected_%0d: got rdy=%b err=%b rdata=%h expected rdy=1 err=1 rdata=deadbeef",
                 i, ready, err, rdata);
      end
      step();
    end
`endif
  endtask

  task automatic test_errors();
    logic        w_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  s_t [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] a_t [3] = '{32'h13, 32'h11, 32'h10};
    int rd0;
    int wr0;
    mem[8] = 32'h0BAD_F00D;
    mem[4] = 32'h7777_7777;
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    step();
    n_vec++;
    if (rdata !== 32'h0BAD_F00D) begin
      n_err++;
      $display("FAIL err_preload: got %h expected 0badf00d", rdata);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      rd0 = rd_pulses;
      wr0 = wr_pulses;
      issue(w_t[i], s_t[i], 1'b0, a_t[i], 32'h0000_5555);
      n_vec++;
      if (ready !== 1'b1 || err !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || rdata !== 32'h0BAD_F00D) begin
        n_err++;
        $display("FAIL err_case_%0d: got rdy=%b err=%b rd=%b wr=%b rdata=%h expected rdy=1 err=1 rd=0 wr=0 rdata=0badf00d",
                 i, ready, err, mem_read, mem_write, rdata);
      end
      step();
      n_vec++;
      if (busy !== 1'b0 || ready !== 1'b0 || rd_pulses != rd0 || wr_pulses != wr0 || mem[4] !== 32'h7777_7777) begin
        n_err++;
        $display("FAIL err_after_%0d: got busy=%b rdy=%b rdp=%0d wrp=%0d ram=%h expected busy=0 rdy=0 rdp=%0d wrp=%0d ram=77777777",
                 i, busy, ready, rd_pulses, wr_pulses, mem[4], rd0, wr0);
      end
    end
  endtask

  task automatic test_busy_wrap();
    int r0;
    int w0;
    int done_c;
    logic [31:0] exp_word;
    mem[4] = 32'h1122_3344;
    r0 = ready_pulses;
    w0 = wr_pulses;
`ifdef DMC_SUBWORD_EN
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h0000_1010; wdata = 32'h0000_005A;
    done_c = 3;
    exp_word = 32'h1122_335A;
`else
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h0000_1010; wdata = 32'h600D_CAFE;
    done_c = 2;
    exp_word = 32'h600D_CAFE;
`endif
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == done_c + 1) req = 1'b0;
      if (c == 1) begin
        n_vec++;
        if (mem_address !== 10'd4 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL wrap_index: got a=%0d busy=%b expected a=4 busy=1", mem_address, busy);
        end
      end
      if (c == done_c) begin
        n_vec++;
        if (ready !== 1'b1 || err !== 1'b0) begin
          n_err++;
          $display("FAIL busy_done: got rdy=%b err=%b expected rdy=1 err=0", ready, err);
        end
      end
    end
    n_vec++;
    if (ready_pulses - r0 != 1 || wr_pulses - w0 != 1 || mem[4] !== exp_word || busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_single_accept: got readys=%0d writes=%0d ram=%h busy=%b expected readys=1 writes=1 ram=%h busy=0",
               ready_pulses - r0, wr_pulses - w0, mem[4], busy, exp_word);
    end
  endtask

  task automatic test_back_to_back();
    int rd0;
    logic exp_rdy;
    mem[8] = 32'h0BAD_F00D;
    rd0 = rd_pulses;
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h20; wdata = 32'h0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 7) req = 1'b0;
      exp_rdy = (c == 2 || c == 5 || c == 8);
      n_vec++;
      if (ready !== exp_rdy) begin
        n_err++;
        $display("FAIL b2b_ready_c%0d: got %b expected %b", c, ready, exp_rdy);
      end
    end
    n_vec++;
    if (rd_pulses - rd0 != 3 || rdata !== 32'h0BAD_F00D) begin
      n_err++;
      $display("FAIL b2b_reads: got reads=%0d rdata=%h expected reads=3 rdata=0badf00d", rd_pulses - rd0, rdata);
    end
  endtask

  task automatic test_reset_abort();
    int r0;
    int w0;
    mem[7] = 32'hA5A5_A5A5;
    r0 = ready_pulses;
    w0 = wr_pulses;
`ifdef DMC_SUBWORD_EN
    issue(1'b1, 2'b00, 1'b0, 32'h1C, 32'h0000_0000);
    n_vec++;
    if (mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL abort_in_rd: got rd=%b expected 1", mem_read);
    end
`else
    issue(1'b1, 2'b10, 1'b0, 32'h1C, 32'h0000_0000);
    n_vec++;
    if (mem_write !== 1'b1) begin
      n_err++;
      $display("FAIL abort_in_wr: got wr=%b expected 1", mem_write);
    end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rdata, ready, err, busy, mem_write, mem_read, mem_address, mem_wdata} !== 79'h0) begin
      n_err++;
      $display("FAIL abort_async_clear: got %h expected 0",
               {rdata, ready, err, busy, mem_write, mem_read, mem_address, mem_wdata});
    end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    n_vec++;
    if (ready_pulses != r0 || wr_pulses != w0 || mem[7] !== 32'hA5A5_A5A5 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_effect: got readys=%0d writes=%0d ram=%h busy=%b expected readys=0 writes=0 ram=a5a5a5a5 busy=0",
               ready_pulses - r0, wr_pulses - w0, mem[7], busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_word_store();
    test_subword_store();
    test_extension();
    test_errors();
    test_busy_wrap();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
